// File: rtl/mux_scan_ctrl.sv
// Scan sequencer/collector for a 64:1 single-bit mux: steps the select, settles, samples, packs a frame.
// Optional continuous rescan after each handshake is enabled by defining MUX_SCAN_CONT_EN.
module mux_scan_ctrl #(
  parameter int NUM_CH = 64,
  parameter int SEL_W  = 6,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic              mux_out,
  output logic [NUM_CH-1:0] frame_data,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMP, S_OUT} state_t;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0] ONE_SEL  = SEL_W'(1);
  localparam logic [3:0]       SETTLE_C = 4'(SETTLE);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              launch_s;

  // Next-state and datapath update for the scan FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    launch_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          launch_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_SAMP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SAMP: begin
        shadow_d[sel_q] = mask_q[sel_q] & mux_out;
        if (sel_q == LAST_SEL) begin
          data_d  = shadow_d;
          valid_d = 1'b1;
          state_d = S_OUT;
        end else begin
          sel_d = sel_q + ONE_SEL;
          // Masked channels skip the settle wait entirely.
          if (!mask_q[sel_d] || (SETTLE == 0)) begin
            state_d = S_SAMP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = SETTLE_C;
          end
        end
      end
      S_OUT: begin
        if (frame_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
`ifdef MUX_SCAN_CONT_EN
          launch_s = 1'b1;
`else
          state_d  = S_IDLE;
`endif
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new scan relatches the mask and restarts from channel 0 with a clean shadow.
    if (launch_s) begin
      mask_d   = ch_mask;
      sel_d    = '0;
      shadow_d = '0;
      if (!ch_mask[0] || (SETTLE == 0)) begin
        state_d = S_SAMP;
      end else begin
        state_d = S_WAIT;
        cnt_d   = SETTLE_C;
      end
    end else begin
      mask_d = mask_d;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any scan in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      sel_q    <= '0;
      mask_q   <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign mux_sel     = sel_q;
  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: single-shot scenarios by default, continuous mode with MUX_SCAN_CONT_EN.
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_CONT_EN
  localparam int TB_SETTLE = 0;
`else
  localparam int TB_SETTLE = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] ch_mask;
  logic [5:0]  mux_sel;
  logic        mux_out;
  logic [63:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        busy;
  logic        done;
  logic [63:0] pattern;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural mux: the scanned bit is the pattern bit addressed by the select.
  assign mux_out = pattern[mux_sel];

  mux_scan_ctrl #(.NUM_CH(64), .SEL_W(6), .SETTLE(TB_SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask),
    .mux_sel(mux_sel), .mux_out(mux_out), .frame_data(frame_data),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .busy(busy), .done(done)
  );

  task automatic kick(input logic [63:0] mask);
    ch_mask = mask;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!frame_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    int vhi;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start       = 1'($urandom_range(1, 0));
      frame_ready = 1'($urandom_range(1, 0));
      ch_mask     = {$urandom, $urandom};
      pattern     = {$urandom, $urandom};
      @(negedge clk);
    end
    checks++;
    if ({mux_sel, frame_data, frame_valid, busy, done} !== 73'd0) begin
      errors++;
      $display("FAIL reset_hold: got sel=%0d data=%h v=%b b=%b d=%b expected all 0",
               mux_sel, frame_data, frame_valid, busy, done);
    end
    start = 1'b0; frame_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({mux_sel, frame_data, frame_valid, busy, done} !== 73'd0) begin
      errors++;
      $display("FAIL reset_release: got sel=%0d data=%h v=%b b=%b d=%b expected all 0",
               mux_sel, frame_data, frame_valid, busy, done);
    end
    vhi = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (frame_valid || busy || done) vhi++;
    end
    checks++;
    if (vhi != 0) begin
      errors++;
      $display("FAIL idle_300: got %0d active cycles expected 0", vhi);
    end
  endtask

  task automatic test_full_scan;
    int n;
    int sel_err;
    frame_ready = 1'b0;
    pattern = 64'hA5A5_0F0F_1234_8001;
    kick(64'hFFFF_FFFF_FFFF_FFFF);
    n = 0; sel_err = 0;
    while (!frame_valid && n < 400) begin
      @(negedge clk);
      n++;
      if (!frame_valid && mux_sel !== 6'(n / 2)) sel_err++;
    end
    checks++;
    if (n != 128) begin
      errors++;
      $display("FAIL full_latency: got %0d expected 128", n);
    end
    checks++;
    if (sel_err != 0) begin
      errors++;
      $display("FAIL full_sel_seq: got %0d bad cycles expected 0", sel_err);
    end
    checks++;
    if (frame_data !== 64'hA5A5_0F0F_1234_8001 || mux_sel !== 6'd63 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_frame: got data=%h sel=%0d busy=%b expected a5a50f0f12348001 63 1",
               frame_data, mux_sel, busy);
    end
    frame_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || frame_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_handshake: got d=%b v=%b b=%b expected 1 0 0", done, frame_valid, busy);
    end
    frame_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL full_done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_partial_mask;
    int n;
    pattern = 64'hFFFF_FFFF_FFFF_FFFF;
    kick(64'h0000_0000_FFFF_FFFF);
    ch_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    wait_valid(400, n);
    checks++;
    if (n != 96) begin
      errors++;
      $display("FAIL partial_latency: got %0d expected 96", n);
    end
    checks++;
    if (frame_data !== 64'h0000_0000_FFFF_FFFF) begin
      errors++;
      $display("FAIL partial_data: got %h expected 00000000ffffffff", frame_data);
    end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold_out;
    int n;
    int bad;
    pattern = 64'hDEAD_BEEF_0123_4567;
    kick(64'hFFFF_FFFF_FFFF_FFFF);
    wait_valid(400, n);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i >= 5 && i <= 7);
      @(negedge clk);
      if (frame_data !== 64'hDEAD_BEEF_0123_4567 || mux_sel !== 6'd63 ||
          frame_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) bad++;
    end
    start = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL out_stable: got %0d unstable cycles expected 0", bad);
    end
    frame_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL out_handshake: got d=%b v=%b expected 1 0", done, frame_valid);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || frame_valid !== 1'b0 || mux_sel !== 6'd63) bad++;
    end
    frame_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL out_idle_after: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_scan;
    int n;
    pattern = 64'hFFFF_FFFF_FFFF_FFFF;
    kick(64'hFFFF_FFFF_FFFF_FFFF);
    n = 0;
    while (mux_sel !== 6'd40 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mux_sel !== 6'd40) begin
      errors++;
      $display("FAIL mid_reach40: got %0d expected 40", mux_sel);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mux_sel, frame_data, frame_valid, busy, done} !== 73'd0) begin
      errors++;
      $display("FAIL mid_reset_clear: got sel=%0d data=%h v=%b b=%b expected all 0",
               mux_sel, frame_data, frame_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pattern = 64'h1;
    kick(64'hFFFF_FFFF_FFFF_FFFF);
    wait_valid(400, n);
    checks++;
    if (n != 128 || frame_data !== 64'h1) begin
      errors++;
      $display("FAIL mid_rescan: got n=%0d data=%h expected 128 0000000000000001", n, frame_data);
    end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_continuous;
    int dones[$];
    int vcnt;
    int bad_data;
    int busy_low;
    frame_ready = 1'b1;
    pattern = 64'h0123_4567_89AB_CDEF;
    kick(64'hFFFF_FFFF_FFFF_FFFF);
    vcnt = 0; bad_data = 0; busy_low = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done) dones.push_back(n);
      if (frame_valid) begin
        vcnt++;
        if (frame_data !== 64'h0123_4567_89AB_CDEF) bad_data++;
      end
      if (!busy) busy_low++;
    end
    checks++;
    if (dones.size() != 3) begin
      errors++;
      $display("FAIL cont_done_count: got %0d expected 3", dones.size());
    end else begin
      checks++;
      if (dones[0] != 65 || dones[1] != 130 || dones[2] != 195) begin
        errors++;
        $display("FAIL cont_period: got %0d %0d %0d expected 65 130 195", dones[0], dones[1], dones[2]);
      end
    end
    checks++;
    if (vcnt != 3 || bad_data != 0) begin
      errors++;
      $display("FAIL cont_frames: got %0d frames %0d bad expected 3 0", vcnt, bad_data);
    end
    checks++;
    if (busy_low != 0) begin
      errors++;
      $display("FAIL cont_busy: got %0d low cycles expected 0", busy_low);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; frame_ready = 1'b0;
    ch_mask = 64'd0; pattern = 64'd0;
    @(negedge clk);
    test_reset;
`ifdef MUX_SCAN_CONT_EN
    test_continuous;
`else
    test_full_scan;
    test_partial_mask;
    test_hold_out;
    test_reset_mid_scan;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
